// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared encodings for the ALU command path: entry phases and ALU opcodes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2
  } phase_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/alu_cmd_sequencer_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, accepted level
// and a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, qualify the level for DEBOUNCE_CYCLES samples, and edge-detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the one on which the count reaches DEBOUNCE_CYCLES.
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects operand A, operand B and opcode from the switches on successive
// NEXT presses and issues them to the ALU atomically with a one-cycle strobe.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] select,
  output logic       issue,
  output logic [1:0] phase,
  output logic [7:0] issue_count
);

  logic   next_press;
  logic   clr_press;
  phase_e phase_q;
  logic [3:0] shadow_a;
  logic [3:0] shadow_b;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_next (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .press(next_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_clr),
    .press(clr_press)
  );

  assign phase = phase_q;

  // Entry state machine with shadow operands and registered command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= LOAD_A;
      shadow_a    <= '0;
      shadow_b    <= '0;
      a           <= '0;
      b           <= '0;
      select      <= '0;
      issue       <= 1'b0;
      issue_count <= '0;
    end else begin
      issue <= 1'b0;
      if (clr_press) begin
        // Clear takes priority over a coincident NEXT; issued command is kept.
        shadow_a <= '0;
        shadow_b <= '0;
        phase_q  <= LOAD_A;
      end else begin
        case (phase_q)
          LOAD_A: if (next_press) begin
            shadow_a <= sw;
            phase_q  <= LOAD_B;
          end
          LOAD_B: if (next_press) begin
            shadow_b <= sw;
            phase_q  <= LOAD_OP;
          end
          LOAD_OP: if (next_press) begin
            a           <= shadow_a;
            b           <= shadow_b;
            select      <= sw[2:0];
            issue       <= 1'b1;
            issue_count <= issue_count + 8'd1;
            phase_q     <= LOAD_A;
          end
          default: phase_q <= LOAD_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: expected commands are queued when
// the final press is started and checked by a monitor on every issue strobe.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned DB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] select;
  logic       issue;
  logic [1:0] phase;
  logic [7:0] issue_count;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [7:0] cnt;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;
  logic issue_prev = 1'b0;

  alu_cmd_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_next   (btn_next),
    .btn_clr    (btn_clr),
    .a          (a),
    .b          (b),
    .select     (select),
    .issue      (issue),
    .phase      (phase),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the command the next LOAD_OP press must produce.
  task automatic expect_cmd(input logic [3:0] ea, input logic [3:0] eb, input logic [2:0] es);
    cmd_t c;
    n_issued++;
    c.a   = ea;
    c.b   = eb;
    c.sel = es;
    c.cnt = 8'(n_issued);
    exp_q.push_back(c);
  endtask

  // Clean press: hold the buttons long enough to be accepted, then release fully.
  task automatic press(input logic [3:0] v, input logic nxt, input logic clr);
    @(negedge clk);
    sw       = v;
    btn_next = nxt;
    btn_clr  = clr;
    repeat (20) @(negedge clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  task automatic command(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vs);
    press(va, 1'b1, 1'b0);
    press(vb, 1'b1, 1'b0);
    expect_cmd(va, vb, vs[2:0]);
    press(vs, 1'b1, 1'b0);
  endtask

  // Monitor: every issue strobe must match the oldest queued command.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (issue_prev && issue) begin
        checks++;
        errors++;
        $display("FAIL issue_width: issue high two cycles in a row");
      end
      if (issue) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: a=%0h b=%0h sel=%0h cnt=%0d", a, b, select, issue_count);
        end else begin
          cmd_t e;
          e = exp_q.pop_front();
          chk("issue_a", 32'(a), 32'(e.a));
          chk("issue_b", 32'(b), 32'(e.b));
          chk("issue_sel", 32'(select), 32'(e.sel));
          chk("issue_cnt", 32'(issue_count), 32'(e.cnt));
          chk("issue_phase", 32'(phase), 32'(LOAD_A));
        end
      end
    end
    issue_prev = issue;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n    = 1'b0;
    sw       = 4'hA;
    btn_next = 1'b0;
    btn_clr  = 1'b0;

    // Reset with bouncing buttons.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn_next = ~btn_next;
      btn_clr  = (i == 1);
    end
    @(negedge clk);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_sel", 32'(select), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_phase", 32'(phase), 32'(LOAD_A));
    chk("rst_cnt", 32'(issue_count), 0);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    rst_n    = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_phase", 32'(phase), 32'(LOAD_A));

    // Nominal entry, with outputs checked before the opcode press.
    press(4'h5, 1'b1, 1'b0);
    chk("nom_phase_b", 32'(phase), 32'(LOAD_B));
    press(4'h3, 1'b1, 1'b0);
    chk("nom_phase_op", 32'(phase), 32'(LOAD_OP));
    chk("nom_a_hold", 32'(a), 0);
    chk("nom_b_hold", 32'(b), 0);
    chk("nom_cnt_hold", 32'(issue_count), 0);
    expect_cmd(4'h5, 4'h3, OP_SUB);
    press(4'b1001, 1'b1, 1'b0);
    chk("nom_a", 32'(a), 5);
    chk("nom_b", 32'(b), 3);
    chk("nom_sel", 32'(select), 32'(OP_SUB));
    chk("nom_cnt", 32'(issue_count), 1);

    // Glitches on NEXT are rejected; clean press latency is measured via issue.
    press(4'hC, 1'b1, 1'b0);
    press(4'hD, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      sw       = 4'h6;
      btn_next = 1'b1;
      repeat (10) @(negedge clk);
      btn_next = 1'b0;
      repeat (20) @(negedge clk);
    end
    chk("glitch_phase", 32'(phase), 32'(LOAD_OP));
    chk("glitch_cnt", 32'(issue_count), 1);
    expect_cmd(4'hC, 4'hD, OP_SHR);
    @(negedge clk);
    btn_next = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (issue && lat < 0) lat = k;
      if (k == 19) @(negedge clk);
    end
    // Issue follows the press pulse by one edge: press at E(DB+2), issue at E(DB+3).
    chk("press_latency", 32'(lat), 32'(DB + 3));
    btn_next = 1'b0;
    repeat (22) @(negedge clk);

    // Clear discards partial entry but keeps the issued command.
    press(4'h7, 1'b1, 1'b0);
    press(4'h2, 1'b1, 1'b0);
    press(4'hF, 1'b0, 1'b1);
    chk("clr_phase", 32'(phase), 32'(LOAD_A));
    chk("clr_a_keep", 32'(a), 32'hC);
    chk("clr_b_keep", 32'(b), 32'hD);
    chk("clr_sel_keep", 32'(select), 32'(OP_SHR));
    chk("clr_cnt_keep", 32'(issue_count), 2);
    command(4'h1, 4'h1, 4'h0);
    chk("clr_a", 32'(a), 1);
    chk("clr_b", 32'(b), 1);
    chk("clr_sel", 32'(select), 32'(OP_ADD));

    // Simultaneous NEXT and CLEAR in LOAD_OP: clear wins, nothing issued.
    press(4'h4, 1'b1, 1'b0);
    press(4'h8, 1'b1, 1'b0);
    press(4'h7, 1'b1, 1'b1);
    chk("sim_phase", 32'(phase), 32'(LOAD_A));
    chk("sim_cnt", 32'(issue_count), 3);
    chk("sim_a_keep", 32'(a), 1);

    // Wrap: bring the total to 256 commands.
    while (n_issued < 256) begin
      logic [3:0] i4;
      i4 = 4'(n_issued);
      command(i4, ~i4, {1'b0, i4[2:0]});
    end
    chk("wrap_cnt", 32'(issue_count), 0);

    // Held NEXT produces one press only.
    @(negedge clk);
    sw       = 4'h9;
    btn_next = 1'b1;
    repeat (1000) @(negedge clk);
    btn_next = 1'b0;
    repeat (22) @(negedge clk);
    chk("hold_phase", 32'(phase), 32'(LOAD_B));
    chk("hold_cnt", 32'(issue_count), 0);

    // Reset mid-entry discards the partial command.
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_phase", 32'(phase), 32'(LOAD_A));
    chk("midrst_a", 32'(a), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
